// File: rtl/simon_uart_rx_block_packer_pkg.sv
// Shared definitions for the Simon UART receive path: rx state encoding,
// 8N1 frame constants and the bit-period calculation.
package simon_uart_rx_block_packer_pkg;

    // Receiver phases of one 8N1 frame
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam int FRAME_DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;

    // Clock cycles per UART bit, truncated the same way on rx and tx sides
    function automatic int calcClksPerBit(input int clkFreqHz, input int baud);
        return clkFreqHz / baud;
    endfunction

endpackage

// File: rtl/simon_uart_rx_block_packer_byte.sv
// UART byte receiver: 2-FF synchroniser, mid-bit sampling FSM and bit counter.
// Emits one-cycle byte strobes for good frames and frame-error pulses for bad stop bits.
module uart_rx_byte
    import simon_uart_rx_block_packer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rxd,
    output logic [7:0] o_byte,
    output logic       o_byteStrobe,
    output logic       o_frameError,
    output logic       o_idle
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT + 1);

    logic      r_sync1;
    logic      r_sync2;
    rx_state_t r_state;
    logic [CW-1:0] r_clkCnt;
    logic [2:0] r_bitIdx;
    logic [7:0] r_shift;

    assign o_idle = (r_state == RX_IDLE);

    // Bring the asynchronous line into the clock domain; preset high so reset looks like an idle line
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= LINE_IDLE;
            r_sync2 <= LINE_IDLE;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Frame FSM: validate start bit at half period, then sample data and stop bits mid-bit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= RX_IDLE;
            r_clkCnt     <= '0;
            r_bitIdx     <= '0;
            r_shift      <= '0;
            o_byte       <= '0;
            o_byteStrobe <= 1'b0;
            o_frameError <= 1'b0;
        end else begin
            o_byteStrobe <= 1'b0;
            o_frameError <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_clkCnt <= '0;
                    r_bitIdx <= '0;
                    if (!r_sync2) begin
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_clkCnt == CW'(HALF_BIT - 1)) begin
                        r_clkCnt <= '0;
                        r_state  <= r_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_clkCnt <= r_clkCnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_clkCnt == CW'(CLKS_PER_BIT - 1)) begin
                        r_clkCnt <= '0;
                        r_shift  <= {r_sync2, r_shift[7:1]};
                        r_bitIdx <= r_bitIdx + 1'b1;
                        if (r_bitIdx == 3'(FRAME_DATA_BITS - 1)) begin
                            r_state <= RX_STOP;
                        end
                    end else begin
                        r_clkCnt <= r_clkCnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_clkCnt == CW'(CLKS_PER_BIT - 1)) begin
                        r_clkCnt <= '0;
                        r_state  <= RX_IDLE;
                        if (r_sync2) begin
                            o_byte       <= r_shift;
                            o_byteStrobe <= 1'b1;
                        end else begin
                            o_frameError <= 1'b1;
                        end
                    end else begin
                        r_clkCnt <= r_clkCnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/simon_uart_rx_block_packer.sv
// Receive front end of the Simon cipher: UART bytes packed into BLOCK_BYTES-wide
// blocks (first byte in the MSBs) and handed to the core over valid/ready.
// The output slot gives one block of slack while the core is busy. BLOCK_BYTES >= 2.
module simon_uart_rx_block_packer
    import simon_uart_rx_block_packer_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int BAUD         = 9600,
    parameter int BLOCK_BYTES  = 8,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rxd_data_in,
    output logic [8*BLOCK_BYTES-1:0] block_data,
    output logic                     block_valid,
    input  logic                     block_ready,
    output logic                     frame_error,
    output logic                     overrun,
    output logic                     timeout
);

    localparam int CLKS_PER_BIT   = calcClksPerBit(CLK_FREQ_HZ, BAUD);
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW             = $clog2(BLOCK_BYTES + 1);

    logic [7:0] w_byte;
    logic       w_byteStrobe;
    logic       w_frameError;
    logic       w_idle;
    logic       w_slotFree;
    logic [8*BLOCK_BYTES-1:0] w_nextBlock;

    logic [8*(BLOCK_BYTES-1)-1:0] r_shiftReg;
    logic [BW-1:0] r_count;
    logic [TW-1:0] r_toCnt;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rxByte (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rxd       (rxd_data_in),
        .o_byte      (w_byte),
        .o_byteStrobe(w_byteStrobe),
        .o_frameError(w_frameError),
        .o_idle      (w_idle)
    );

    assign frame_error = w_frameError;
    assign w_nextBlock = {r_shiftReg, w_byte};
    assign w_slotFree  = !block_valid || block_ready;

    // Pack bytes, load the output slot on block completion, and drop stale partial blocks after idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shiftReg  <= '0;
            r_count     <= '0;
            r_toCnt     <= '0;
            block_data  <= '0;
            block_valid <= 1'b0;
            overrun     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            timeout <= 1'b0;
            if (block_valid && block_ready) begin
                block_valid <= 1'b0;
            end
            if (w_byteStrobe) begin
                r_shiftReg <= w_nextBlock[8*(BLOCK_BYTES-1)-1:0];
                r_toCnt    <= '0;
                if (r_count == BW'(BLOCK_BYTES - 1)) begin
                    r_count <= '0;
                    if (w_slotFree) begin
                        block_data  <= w_nextBlock;
                        block_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_idle && (r_count != '0)) begin
                if (r_toCnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    r_toCnt <= '0;
                    r_count <= '0;
                    timeout <= 1'b1;
                end else begin
                    r_toCnt <= r_toCnt + 1'b1;
                end
            end else begin
                r_toCnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_simon_uart_rx_block_packer.sv
// Scoreboard bench for simon_uart_rx_block_packer at a fast line rate (16 clocks per bit).
// A byte-level reference model predicts blocks and pulse counts; a negedge monitor checks them.
module tb_simon_uart_rx_block_packer;

    localparam int CPB  = 16;
    localparam int BB   = 8;
    localparam int TOB  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rxd;
    logic          ready;
    logic [63:0]   blockData;
    logic          blockValid;
    logic          frameError;
    logic          overrunPulse;
    logic          timeoutPulse;

    int total = 0;
    int bad   = 0;

    logic [63:0] expQ[$];
    logic [7:0]  partial[$];
    int expFe = 0, expOv = 0, expTo = 0, expBlocks = 0;
    int seenFe = 0, seenOv = 0, seenTo = 0, blocksSeen = 0;
    bit slotFull = 1'b0;
    logic prevValid = 1'b0;

    simon_uart_rx_block_packer #(
        .CLK_FREQ_HZ (100_000_000),
        .BAUD        (100_000_000 / CPB),
        .BLOCK_BYTES (BB),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd_data_in(rxd),
        .block_data (blockData),
        .block_valid(blockValid),
        .block_ready(ready),
        .frame_error(frameError),
        .overrun    (overrunPulse),
        .timeout    (timeoutPulse)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Record one comparison and report it if it does not hold
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Advance n rising edges and step just past the edge so drives and samples avoid races
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a good byte joins the pending block; the BB-th byte completes it
    task automatic modelByte(input logic [7:0] b, input bit stopOk);
        logic [63:0] blk;
        if (!stopOk) begin
            expFe++;
            return;
        end
        partial.push_back(b);
        if (partial.size() == BB) begin
            blk = '0;
            foreach (partial[i]) blk = {blk[55:0], partial[i]};
            partial.delete();
            if (slotFull) begin
                expOv++;
            end else begin
                expQ.push_back(blk);
                expBlocks++;
                slotFull = !ready;
            end
        end
    endtask

    // Predict then drive one 8N1 frame followed by gapBits of idle line
    task automatic applyStimulus(input logic [7:0] b, input bit stopBit, input int gapBits);
        modelByte(b, stopBit);
        rxd = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            waitCycles(CPB);
        end
        rxd = stopBit;
        waitCycles(CPB);
        rxd = 1'b1;
        waitCycles(gapBits * CPB);
    endtask

    // Monitor: count pulses, check exclusivity, pop the scoreboard on each handshake, check held data
    always @(negedge clk) begin
        if (frameError)   seenFe++;
        if (overrunPulse) seenOv++;
        if (timeoutPulse) seenTo++;
        if (frameError || overrunPulse || timeoutPulse) begin
            checkOutput("pulse_exclusive", 64'(int'(frameError) + int'(overrunPulse) + int'(timeoutPulse)), 64'd1);
        end
        if (blockValid && !prevValid && expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_block: got %h want no block", blockData);
        end
        if (blockValid && ready && expQ.size() > 0) begin
            checkOutput("block", blockData, expQ.pop_front());
            blocksSeen++;
        end else if (blockValid && !ready && expQ.size() > 0) begin
            checkOutput("held_block", blockData, expQ[0]);
        end
        prevValid <= blockValid;
    end

    // Hard time limit so the run always ends
    initial begin
        #900_000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        logic [7:0] b;
        bit         stopOk;
        int         blocksBefore;

        rst   = 1'b1;
        rxd   = 1'b1;
        ready = 1'b0;
        waitCycles(5);
        checkOutput("reset_valid", 64'(blockValid), 64'd0);
        checkOutput("reset_data", blockData, 64'd0);
        checkOutput("reset_fe", 64'(frameError), 64'd0);
        checkOutput("reset_ov", 64'(overrunPulse), 64'd0);
        checkOutput("reset_to", 64'(timeoutPulse), 64'd0);
        rst = 1'b0;
        waitCycles(2 * CPB);

        $display("[TB] scenario 1: block held until ready");
        for (int i = 1; i <= 8; i++) applyStimulus(8'(i), 1'b1, 1);
        checkOutput("t1_valid", 64'(blockValid), 64'd1);
        checkOutput("t1_data", blockData, 64'h0102030405060708);
        waitCycles(200);
        checkOutput("t1_data_held", blockData, 64'h0102030405060708);
        ready = 1'b1;
        waitCycles(1);
        checkOutput("t1_valid_drop", 64'(blockValid), 64'd0);
        slotFull = 1'b0;

        $display("[TB] scenario 2: line glitch rejected");
        rxd = 1'b0;
        waitCycles(4);
        rxd = 1'b1;
        waitCycles(2 * CPB);
        checkOutput("t2_no_fe", 64'(seenFe), 64'(expFe));
        applyStimulus(8'hA5, 1'b1, 1);
        for (int i = 0; i < 7; i++) applyStimulus(8'($urandom_range(0, 255)), 1'b1, 1);

        $display("[TB] scenario 3: bad stop bit drops one byte");
        applyStimulus(8'h31, 1'b1, 1);
        applyStimulus(8'h32, 1'b1, 1);
        applyStimulus(8'h33, 1'b0, 1);
        checkOutput("t3_fe", 64'(seenFe), 64'(expFe));
        for (int i = 4; i <= 9; i++) applyStimulus(8'(8'h30 + i), 1'b1, 1);
        waitCycles(4);
        checkOutput("t3_blocks", 64'(blocksSeen), 64'(expBlocks));

        $display("[TB] scenario 4: overrun while slot full");
        ready = 1'b0;
        for (int i = 0; i < 16; i++) applyStimulus(8'(8'h10 + i), 1'b1, 0);
        waitCycles(4);
        checkOutput("t4_data", blockData, 64'h1011121314151617);
        checkOutput("t4_ov", 64'(seenOv), 64'(expOv));
        ready = 1'b1;
        waitCycles(2);
        slotFull = 1'b0;

        $display("[TB] scenario 5: partial block timeout");
        applyStimulus(8'h40, 1'b1, 0);
        applyStimulus(8'h41, 1'b1, 0);
        applyStimulus(8'h42, 1'b1, 0);
        waitCycles(14 * CPB);
        checkOutput("t5_no_early_to", 64'(seenTo), 64'(expTo));
        waitCycles(6 * CPB);
        expTo++;
        partial.delete();
        checkOutput("t5_to", 64'(seenTo), 64'(expTo));
        for (int i = 1; i <= 8; i++) applyStimulus(8'(8'h20 + i), 1'b1, 1);

        $display("[TB] scenario 6: reset mid-byte");
        for (int i = 0; i < 4; i++) applyStimulus(8'(8'h50 + i), 1'b1, 1);
        b = 8'h5C;
        rxd = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            waitCycles(CPB);
        end
        rxd = b[4];
        waitCycles(CPB / 2);
        rst = 1'b1;
        rxd = 1'b1;
        partial.delete();
        waitCycles(2);
        checkOutput("t6_valid", 64'(blockValid), 64'd0);
        checkOutput("t6_data", blockData, 64'd0);
        checkOutput("t6_pulses", 64'({frameError, overrunPulse, timeoutPulse}), 64'd0);
        waitCycles(3);
        rst = 1'b0;
        waitCycles(2 * CPB);
        blocksBefore = blocksSeen;
        for (int i = 0; i < 8; i++) applyStimulus(8'($urandom_range(0, 255)), 1'b1, 1);
        waitCycles(4);
        checkOutput("t6_one_block", 64'(blocksSeen - blocksBefore), 64'd1);

        $display("[TB] random traffic");
        for (int i = 0; i < 30; i++) begin
            stopOk = ($urandom_range(0, 7) != 0);
            applyStimulus(8'($urandom_range(0, 255)), stopOk, stopOk ? $urandom_range(0, 2) : $urandom_range(1, 2));
        end
        while (partial.size() != 0) applyStimulus(8'($urandom_range(0, 255)), 1'b1, $urandom_range(0, 2));
        waitCycles(50);

        checkOutput("end_queue_empty", 64'(expQ.size()), 64'd0);
        checkOutput("end_blocks", 64'(blocksSeen), 64'(expBlocks));
        checkOutput("end_fe", 64'(seenFe), 64'(expFe));
        checkOutput("end_ov", 64'(seenOv), 64'(expOv));
        checkOutput("end_to", 64'(seenTo), 64'(expTo));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
